// File: rtl/frame_buffer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : frame_buffer_arbiter
//  Purpose  : Buffers downsampled pixels, shares one RAM port between the
//             frame writer and a byte reader, and ping-pongs frame banks.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_buffer_arbiter #(
   parameter int WIDTH      = 400,
   parameter int HEIGHT     = 300,
   parameter int ADDR_W     = 17,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pix_valid,
   input  logic [7:0]        pix_data,
   input  logic              pix_blanking,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic              rd_valid,
   output logic [7:0]        rd_data,
   output logic [ADDR_W:0]   mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              frame_ready,
   output logic              read_bank,
   output logic              overflow
);

   localparam int                 C_PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int                 C_CNT_W     = C_PTR_W + 1;
   localparam logic [C_CNT_W-1:0] C_FULL      = C_CNT_W'(FIFO_DEPTH);
   localparam logic [C_CNT_W-1:0] C_WR_PRIO   = C_CNT_W'(FIFO_DEPTH - 1);
   localparam logic [ADDR_W-1:0]  C_LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

   logic [7:0]         r_fifo_mem [FIFO_DEPTH];
   logic [C_PTR_W-1:0] r_wr_ptr;
   logic [C_PTR_W-1:0] r_rd_ptr;
   logic [C_CNT_W-1:0] r_count;
   logic [ADDR_W-1:0]  r_wr_addr;
   logic               r_wr_bank;
   logic               r_frame_ready;
   logic               r_overflow;
   logic               r_rd_valid;
   logic [ADDR_W:0]    r_last_addr;

   logic               w_push_req;
   logic               w_full;
   logic               w_push;
   logic               w_wr_grant;
   logic               w_rd_grant;
   logic               w_read_bank;
   logic [ADDR_W:0]    w_access_addr;

   assign w_push_req  = pix_valid & ~pix_blanking;
   assign w_full      = (r_count == C_FULL);
   // A full FIFO refuses the pixel even if an entry drains in the same cycle.
   assign w_push      = w_push_req & ~w_full;
   assign w_read_bank = ~r_wr_bank;

   // Writer wins once the FIFO is nearly full so pixels keep flowing under a
   // continuous read stream; reset gating keeps the handshake quiet in reset.
   assign w_wr_grant = ~reset & ((r_count >= C_WR_PRIO) |
                                 ((r_count != '0) & ~rd_req));
   assign w_rd_grant = ~reset & rd_req & ~w_wr_grant;

   assign w_access_addr = w_wr_grant ? {r_wr_bank, r_wr_addr}
                                     : {w_read_bank, rd_addr};

   assign mem_we      = w_wr_grant;
   assign mem_addr    = (w_wr_grant | w_rd_grant) ? w_access_addr : r_last_addr;
   assign mem_wdata   = w_wr_grant ? r_fifo_mem[r_rd_ptr] : 8'h00;
   assign rd_ack      = w_rd_grant;
   assign rd_valid    = r_rd_valid;
   assign rd_data     = r_rd_valid ? mem_rdata : 8'h00;
   assign frame_ready = r_frame_ready;
   assign read_bank   = w_read_bank;
   assign overflow    = r_overflow;

   // Storage only; occupancy is tracked by the pointers and count below.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo_mem[r_wr_ptr] <= pix_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_wr_addr     <= '0;
         r_wr_bank     <= 1'b0;
         r_frame_ready <= 1'b0;
         r_overflow    <= 1'b0;
         r_rd_valid    <= 1'b0;
         r_last_addr   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
         end
         if (w_wr_grant) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
         end

         case ({w_push, w_wr_grant})
            2'b10:   r_count <= r_count + C_CNT_W'(1);
            2'b01:   r_count <= r_count - C_CNT_W'(1);
            default: r_count <= r_count;
         endcase

         if (w_push_req & w_full) begin
            r_overflow <= 1'b1;
         end

         r_frame_ready <= 1'b0;
         if (w_wr_grant) begin
            if (r_wr_addr == C_LAST_ADDR) begin
               r_wr_addr     <= '0;
               r_wr_bank     <= ~r_wr_bank;
               r_frame_ready <= 1'b1;
            end else begin
               r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
         end

         r_rd_valid <= w_rd_grant;

         if (w_wr_grant | w_rd_grant) begin
            r_last_addr <= w_access_addr;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_arbiter.sv
`default_nettype none
// Randomised bench for frame_buffer_arbiter: a queue/array reference model
// predicts every output each cycle; a few literal checks pin the model.
module tb_frame_buffer_arbiter;

   localparam int WIDTH      = 8;
   localparam int HEIGHT     = 6;
   localparam int ADDR_W     = 6;
   localparam int FIFO_DEPTH = 4;
   localparam int N          = WIDTH * HEIGHT;
   localparam int ABANK      = 1 << ADDR_W;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              pix_valid = 1'b0;
   logic [7:0]        pix_data = 8'h00;
   logic              pix_blanking = 1'b0;
   logic              rd_req = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic              rd_ack;
   logic              rd_valid;
   logic [7:0]        rd_data;
   logic [ADDR_W:0]   mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata = 8'h00;
   logic              frame_ready;
   logic              read_bank;
   logic              overflow;

   frame_buffer_arbiter #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clock(clock), .reset(reset),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_blanking(pix_blanking),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .frame_ready(frame_ready), .read_bank(read_bank), .overflow(overflow)
   );

   always #5 clock = ~clock;

   // Single-port RAM with one cycle read latency.
   logic [7:0] ram [2*ABANK];
   always @(posedge clock) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   byte unsigned m_q[$];
   logic [7:0]   m_mem [2*ABANK];
   int  m_wr_addr, m_wr_bank, m_last, m_writes, m_frames, m_max_q;
   bit  m_ovf, m_fr, m_rv;
   int  m_rdat;
   int  fr_seen, rv_seen;
   bit  ack_prev;
   int  sz, rb, e_addr, e_wdata;
   bit  wg, rg, full;

   always @(negedge clock) begin
      if (reset) begin
         m_q.delete();
         m_wr_addr = 0; m_wr_bank = 0; m_last = 0;
         m_ovf = 0; m_fr = 0; m_rv = 0; m_rdat = 0;
         ack_prev = 0;
         check("reset_flags", 32'({rd_ack, rd_valid, mem_we, frame_ready, overflow, read_bank}), 32'h1);
         check("reset_bus", 32'({mem_addr, mem_wdata, rd_data}), 32'h0);
      end else begin
         rb = 1 - m_wr_bank;
         sz = m_q.size();
         wg = (sz >= FIFO_DEPTH - 1) || (sz > 0 && !rd_req);
         rg = rd_req && !wg;
         if (wg)      e_addr = m_wr_bank * ABANK + m_wr_addr;
         else if (rg) e_addr = rb * ABANK + int'(rd_addr);
         else         e_addr = m_last;
         e_wdata = wg ? int'(m_q[0]) : 0;

         check("mem_we", 32'(mem_we), 32'(wg));
         check("rd_ack", 32'(rd_ack), 32'(rg));
         check("mem_addr", 32'(mem_addr), e_addr);
         check("mem_wdata", 32'(mem_wdata), e_wdata);
         check("rd_valid", 32'(rd_valid), 32'(m_rv));
         check("rd_data", 32'(rd_data), m_rv ? m_rdat : 0);
         check("frame_ready", 32'(frame_ready), 32'(m_fr));
         check("read_bank", 32'(read_bank), rb);
         check("overflow", 32'(overflow), 32'(m_ovf));

         fr_seen += int'(frame_ready);
         rv_seen += int'(rd_valid);
         ack_prev = rd_ack;

         full = (sz == FIFO_DEPTH);
         m_fr = 0;
         if (wg) begin
            m_mem[e_addr] = m_q.pop_front();
            m_writes++;
            if (m_wr_addr == N - 1) begin
               m_wr_addr = 0;
               m_wr_bank = 1 - m_wr_bank;
               m_fr = 1;
               m_frames++;
            end else begin
               m_wr_addr++;
            end
         end
         m_rv   = rg;
         m_rdat = rg ? int'(m_mem[e_addr]) : 0;
         if (pix_valid && !pix_blanking) begin
            if (full) m_ovf = 1;
            else      m_q.push_back(pix_data);
         end
         m_last = e_addr;
         if (m_q.size() > m_max_q) m_max_q = m_q.size();
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   int w0, npush, k;
   bit done;

   initial begin
      for (int i = 0; i < 2*ABANK; i++) begin
         ram[i]   = 8'h00;
         m_mem[i] = 8'h00;
      end
      m_writes = 0; m_frames = 0; m_max_q = 0; fr_seen = 0; rv_seen = 0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      check("init_read_bank", 32'(read_bank), 32'h1);
      check("init_overflow", 32'(overflow), 32'h0);

      // One full frame, a pixel every second cycle, no reads
      for (int i = 0; i < N; i++) begin
         pix_valid = 1'b1; pix_data = 8'(i % 256);
         cyc();
         pix_valid = 1'b0;
         cyc();
      end
      repeat (4) cyc();
      check("frame_pulses", 32'(fr_seen), 32'd1);
      check("model_frames", 32'(m_frames), 32'd1);
      check("model_writes", 32'(m_writes), 32'(N));
      check("read_bank_after_frame", 32'(read_bank), 32'h0);
      check("ram_bank0_byte37", 32'(ram[37]), 32'd37);
      check("ram_bank0_last", 32'(ram[N-1]), 32'(N-1));

      // Single read with an empty FIFO
      rd_req = 1'b1; rd_addr = ADDR_W'(17);
      #1;
      check("single_rd_ack", 32'(rd_ack), 32'h1);
      check("single_rd_addr", 32'(mem_addr), 32'd17);
      cyc();
      rd_req = 1'b0;
      #1;
      check("single_rd_valid", 32'(rd_valid), 32'h1);
      check("single_rd_data", 32'(rd_data), 32'd17);
      cyc();

      // Random valid/blanking mix, no reads
      w0 = m_writes; npush = 0;
      for (int i = 0; i < 60; i++) begin
         pix_valid    = 1'($urandom_range(0, 1));
         pix_blanking = 1'($urandom_range(0, 1));
         pix_data     = 8'($urandom);
         if (pix_valid && !pix_blanking) npush++;
         cyc();
      end
      pix_valid = 1'b0; pix_blanking = 1'b0;
      repeat (6) cyc();
      check("blanking_write_count", 32'(m_writes - w0), 32'(npush));

      // Continuous read at address 5 while pixels stream every second cycle
      m_max_q = 0; rv_seen = 0;
      rd_req = 1'b1; rd_addr = ADDR_W'(5);
      for (int i = 0; i < 40; i++) begin
         pix_valid = 1'b1; pix_data = 8'($urandom);
         cyc();
         pix_valid = 1'b0;
         cyc();
      end
      check("held_read_fifo_max", 32'(m_max_q <= 3), 32'h1);
      check("held_read_progress", 32'(rv_seen > 10), 32'h1);

      // Push every cycle with the read held
      m_max_q = 0;
      for (int i = 0; i < 40; i++) begin
         pix_valid = 1'b1; pix_data = 8'($urandom);
         cyc();
      end
      pix_valid = 1'b0;
      check("burst_fifo_max", 32'(m_max_q), 32'd3);
      check("burst_overflow", 32'(overflow), 32'h0);
      rd_req = 1'b0;
      repeat (6) cyc();

      // Random traffic with a well-behaved reader
      for (int i = 0; i < 1500; i++) begin
         pix_valid    = ($urandom_range(0, 99) < 60);
         pix_blanking = ($urandom_range(0, 99) < 10);
         pix_data     = 8'($urandom);
         if (!rd_req || ack_prev) begin
            rd_req  = 1'($urandom_range(0, 1));
            rd_addr = ADDR_W'($urandom);
         end
         cyc();
      end
      pix_valid = 1'b0; pix_blanking = 1'b0; rd_req = 1'b0;
      repeat (6) cyc();

      // Reset mid-frame once the write address reaches 20
      done = 0;
      for (k = 0; k < 200 && !done; k++) begin
         if (m_wr_addr == 20) done = 1;
         else begin
            pix_valid = 1'b1; pix_data = 8'($urandom);
            cyc();
         end
      end
      check("midframe_reached", 32'(done), 32'h1);
      pix_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("async_clear_flags", 32'({rd_ack, rd_valid, mem_we, frame_ready, overflow, read_bank}), 32'h1);
      check("async_clear_addr", 32'(mem_addr), 32'h0);
      cyc();
      reset = 1'b0;
      pix_valid = 1'b1; pix_data = 8'hA5;
      cyc();
      pix_valid = 1'b0;
      done = 0;
      for (k = 0; k < 10 && !done; k++) begin
         #1;
         if (mem_we) begin
            done = 1;
            check("post_reset_addr", 32'(mem_addr), 32'h0);
            check("post_reset_data", 32'(mem_wdata), 32'hA5);
         end else begin
            cyc();
         end
      end
      check("post_reset_write_seen", 32'(done), 32'h1);
      repeat (4) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
